mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_defs.sv | 16 +
 rtl/mdu_calc.sv | 30 +++
 rtl/mdu.sv | 53 +++++
 tb/tb_mdu.sv | 111 +++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// mdu_defs: shared encodings, latencies and FSM states for the multiply/divide unit.
package mdu_defs;
  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;
  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational multiply/divide datapath producing {HI,LO} and a divide-by-zero flag.
module mdu_calc
  import mdu_defs::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [63:0] o_res,
  output logic        o_dz
);
  logic        w_sgn;
  logic [63:0] w_ea, w_eb, w_prod;
  logic [31:0] w_ma, w_mb, w_dvs, w_uq, w_ur, w_q, w_r;
  always_comb begin
    w_sgn  = (i_op == MD_MULT) || (i_op == MD_DIV);
    w_ea   = {{32{w_sgn & i_a[31]}}, i_a};
    w_eb   = {{32{w_sgn & i_b[31]}}, i_b};
    w_prod = w_ea * w_eb;
    // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly.
    w_ma   = (w_sgn && i_a[31]) ? -i_a : i_a;
    w_mb   = (w_sgn && i_b[31]) ? -i_b : i_b;
    w_dvs  = (w_mb == 32'd0) ? 32'd1 : w_mb;
    w_uq   = w_ma / w_dvs;
    w_ur   = w_ma % w_dvs;
    w_q    = (w_sgn && (i_a[31] ^ i_b[31])) ? -w_uq : w_uq;
    w_r    = (w_sgn && i_a[31]) ? -w_ur : w_ur;
    o_dz   = (i_b == 32'd0);
    o_res  = ((i_op == MD_DIV) || (i_op == MD_DIVU)) ? {w_r, w_q} : w_prod;
  end
endmodule

// File: rtl/mdu.sv
// mdu: multicycle multiply/divide unit; results wait in shadow registers until the
// busy countdown expires, then commit to HI/LO.
module mdu
  import mdu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_shadow;
  logic [63:0] w_res;
  logic        w_dz, w_mul, w_div;
  mdu_calc u_calc (.i_a(A), .i_b(B), .i_op(MDOp), .o_res(w_res), .o_dz(w_dz));
  assign w_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
  assign w_div = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_shadow <= 64'd0;
      Busy     <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else if (r_state == S_IDLE) begin
      if (Start && (w_mul || w_div)) begin
        // Divide-by-zero shadows the current HI/LO so commit leaves them unchanged.
        r_shadow <= (w_div && w_dz) ? {HI, LO} : w_res;
        r_cnt    <= w_mul ? MULT_LAT : DIV_LAT;
        r_state  <= S_BUSY;
        Busy     <= 1'b1;
      end else if (Start && MDOp == MD_MTHI) begin
        HI <= A;
      end else if (Start && MDOp == MD_MTLO) begin
        LO <= A;
      end
    end else if (r_cnt == 4'd1) begin
      {HI, LO} <= r_shadow;
      r_cnt    <= 4'd0;
      r_state  <= S_IDLE;
      Busy     <= 1'b0;
    end else begin
      r_cnt <= r_cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors with hand-computed results for the multiply/divide unit.
module tb_mdu;
  logic        clk, reset, Start, Busy;
  logic [31:0] A, B, HI, LO;
  logic [2:0]  MDOp;
  int n_cmp = 0;
  int n_err = 0;
  mdu dut (.clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
           .Busy(Busy), .HI(HI), .LO(LO));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; MDOp = op; Start = 1'b1;
    tick();
    Start = 1'b0; MDOp = 3'b000;
  endtask
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    logic [31:0] ohi, olo;
    ohi = HI; olo = LO;
    issue(op, a, b);
    chk({tag, " busy1"}, {31'd0, Busy}, 32'd1);
    for (int i = 2; i <= lat; i++) begin
      tick();
      chk($sformatf("%s busy%0d", tag, i), {31'd0, Busy}, 32'd1);
    end
    chk({tag, " hi held"}, HI, ohi);
    chk({tag, " lo held"}, LO, olo);
    tick();
    chk({tag, " busy done"}, {31'd0, Busy}, 32'd0);
    chk({tag, " hi"}, HI, ehi);
    chk({tag, " lo"}, LO, elo);
  endtask
  initial begin
    reset = 1'b0; Start = 1'b0; A = '0; B = '0; MDOp = 3'b000;
    #3;
    chk("rst busy", {31'd0, Busy}, 32'd0);
    chk("rst hi", HI, 32'd0);
    chk("rst lo", LO, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    run_op("mult", 3'b001, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    run_op("div", 3'b011, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("divu", 3'b100, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("mult mix", 3'b001, 32'd7, 32'hFFFFFFFD, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);
    issue(3'b101, 32'h11, 32'd0);
    chk("mthi11 busy", {31'd0, Busy}, 32'd0);
    issue(3'b110, 32'h22, 32'd0);
    chk("mtlo22 busy", {31'd0, Busy}, 32'd0);
    chk("mtlo22 lo", LO, 32'h22);
    chk("mthi11 hi", HI, 32'h11);
    run_op("divu0", 3'b100, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    issue(3'b101, 32'h12345678, 32'd0);
    chk("mthi busy", {31'd0, Busy}, 32'd0);
    chk("mthi hi", HI, 32'h12345678);
    chk("mthi lo", LO, 32'h22);
    issue(3'b000, 32'hDEAD, 32'hBEEF);
    chk("none busy", {31'd0, Busy}, 32'd0);
    issue(3'b111, 32'hDEAD, 32'hBEEF);
    chk("rsvd busy", {31'd0, Busy}, 32'd0);
    chk("rsvd hi", HI, 32'h12345678);
    chk("rsvd lo", LO, 32'h22);
    // MULT 5*6 with a DIV 100/3 attempted on its third busy cycle.
    issue(3'b001, 32'd5, 32'd6);
    tick(); tick();
    chk("ign busy3", {31'd0, Busy}, 32'd1);
    issue(3'b011, 32'd100, 32'd3);
    tick();
    chk("ign busy5", {31'd0, Busy}, 32'd1);
    tick();
    chk("ign busy done", {31'd0, Busy}, 32'd0);
    chk("ign hi", HI, 32'd0);
    chk("ign lo", LO, 32'd30);
    tick();
    chk("ign stays idle", {31'd0, Busy}, 32'd0);
    issue(3'b101, 32'hCAFE0001, 32'd0);
    chk("pre-abort hi", HI, 32'hCAFE0001);
    // Abort a DIV on its fourth busy cycle with an asynchronous reset.
    issue(3'b011, 32'd100, 32'd3);
    tick(); tick(); tick();
    chk("abort busy4", {31'd0, Busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort busy", {31'd0, Busy}, 32'd0);
    chk("abort hi", HI, 32'd0);
    chk("abort lo", LO, 32'd0);
    repeat (12) tick();
    chk("abort no commit lo", LO, 32'd0);
    reset = 1'b1;
    tick();
    run_op("post rst", 3'b001, 32'd2, 32'd3, 5, 32'd0, 32'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
